// File: rtl/alu_sel_decoder.sv
// alu_sel_decoder: registered one-hot ALU unit-select decoder with a HOLD-cycle, back-pressured dispatch.
// Optional macro DEC_ERR_EN adds the err pulse and rejects codes sel >= NUM_OUT without entering ACTIVE.
module alu_sel_decoder #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int HOLD    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    output logic               sel_ready,
    output logic [NUM_OUT-1:0] onehot,
    output logic               busy,
    output logic               done
`ifdef DEC_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int CNT_W = $clog2(HOLD) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    if (SEL_W < 1 || SEL_W > 6) begin : g_bad_sel_w
        $error("alu_sel_decoder: SEL_W must be in 1..6");
    end
    if (NUM_OUT < 1 || NUM_OUT > (1 << SEL_W)) begin : g_bad_num_out
        $error("alu_sel_decoder: NUM_OUT must be in 1..2**SEL_W");
    end
    if (HOLD < 1 || HOLD > 256) begin : g_bad_hold
        $error("alu_sel_decoder: HOLD must be in 1..256");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_q_next;
    logic [NUM_OUT-1:0] onehot_next;
    logic               busy_next;
    logic               done_next;
    logic               accept;
    logic               start;

    // Codes at or above NUM_OUT decode to an all-zero vector.
    function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] code);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (32'(code) == 32'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign sel_ready = (state == IDLE) && !rst;
    assign accept    = sel_valid && sel_ready;

`ifdef DEC_ERR_EN
    localparam bit ALL_LEGAL = (NUM_OUT == (1 << SEL_W));

    logic code_illegal;
    logic err_next;

    assign code_illegal = ALL_LEGAL ? 1'b0 : (32'(sel) >= 32'(NUM_OUT));
    assign start        = accept && !code_illegal;
    assign err_next     = accept && code_illegal;
`else
    assign start = accept;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            onehot <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef DEC_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            sel_q  <= sel_q_next;
            onehot <= onehot_next;
            busy   <= busy_next;
            done   <= done_next;
`ifdef DEC_ERR_EN
            err    <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_q_next = sel_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACTIVE;
                    cnt_next   = CNT_LOAD;
                    sel_q_next = sel;
                end
            end
            ACTIVE: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Held cycles re-decode from sel_q so onehot stays a pure register output.
    always_comb begin
        onehot_next = '0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    onehot_next = decode(sel);
                    busy_next   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt != '0) begin
                    onehot_next = decode(sel_q);
                    busy_next   = 1'b1;
                end else begin
                    done_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sel_decoder.sv
// tb_alu_sel_decoder: drives three decoder configurations and checks them against a timestamp-based model.
// Configs: A (SEL_W=2,NUM_OUT=4,HOLD=1), B (SEL_W=2,NUM_OUT=3,HOLD=3), C (SEL_W=3,NUM_OUT=8,HOLD=256).
module tb_alu_sel_decoder;

    logic clk = 1'b0;
    logic rst;

    logic       va, vb, vc;
    logic [1:0] sa, sb;
    logic [2:0] sc;
    logic       ra, rb, rc;
    logic [3:0] oa;
    logic [2:0] ob;
    logic [7:0] oc;
    logic       ba, bb, bc;
    logic       da, db, dc;
`ifdef DEC_ERR_EN
    logic       ea, eb, ec;
`endif

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    int n = 0;
    int hold_p [3] = '{1, 3, 256};
    int nout   [3] = '{4, 3, 8};
    int smax   [3] = '{3, 3, 7};
    int acc    [3] = '{-1000000, -1000000, -1000000};
    int code   [3] = '{0, 0, 0};
    int err_at [3] = '{-1000000, -1000000, -1000000};
    bit cur_v  [3] = '{0, 0, 0};
    int cur_s  [3] = '{0, 0, 0};
    bit taken  [3] = '{0, 0, 0};

    alu_sel_decoder #(.SEL_W(2), .NUM_OUT(4), .HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .sel_valid(va), .sel(sa), .sel_ready(ra),
`ifdef DEC_ERR_EN
        .err(ea),
`endif
        .onehot(oa), .busy(ba), .done(da)
    );

    alu_sel_decoder #(.SEL_W(2), .NUM_OUT(3), .HOLD(3)) dut_b (
        .clk(clk), .rst(rst), .sel_valid(vb), .sel(sb), .sel_ready(rb),
`ifdef DEC_ERR_EN
        .err(eb),
`endif
        .onehot(ob), .busy(bb), .done(db)
    );

    alu_sel_decoder #(.SEL_W(3), .NUM_OUT(8), .HOLD(256)) dut_c (
        .clk(clk), .rst(rst), .sel_valid(vc), .sel(sc), .sel_ready(rc),
`ifdef DEC_ERR_EN
        .err(ec),
`endif
        .onehot(oc), .busy(bc), .done(dc)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] get_onehot(input int d);
        case (d)
            0:       return {4'b0, oa};
            1:       return {5'b0, ob};
            default: return oc;
        endcase
    endfunction

    // {ready, busy, done, err}
    function automatic logic [3:0] get_flags(input int d);
        logic e;
        e = 1'b0;
`ifdef DEC_ERR_EN
        case (d)
            0:       e = ea;
            1:       e = eb;
            default: e = ec;
        endcase
`endif
        case (d)
            0:       return {ra, ba, da, e};
            1:       return {rb, bb, db, e};
            default: return {rc, bc, dc, e};
        endcase
    endfunction

    // A command accepted at edge acc occupies edges acc..acc+HOLD-1 and completes at acc+HOLD.
    function automatic bit m_active(input int d);
        return (n >= acc[d]) && (n - acc[d] < hold_p[d]);
    endfunction

    function automatic bit m_done(input int d);
        return (n - acc[d]) == hold_p[d];
    endfunction

    function automatic logic [7:0] m_onehot(input int d);
        logic [7:0] one;
        one = 8'd1;
        if (!m_active(d) || code[d] >= nout[d]) return 8'd0;
        return one << code[d];
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] f;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            f = get_flags(d);
            check_output($sformatf("dut%0d onehot n=%0d", d, n), get_onehot(d), m_onehot(d));
            check_output($sformatf("dut%0d busy n=%0d", d, n), {7'b0, f[2]}, {7'b0, m_active(d)});
            check_output($sformatf("dut%0d done n=%0d", d, n), {7'b0, f[1]}, {7'b0, m_done(d)});
            check_output($sformatf("dut%0d ready n=%0d", d, n), {7'b0, f[3]},
                         {7'b0, !m_active(d) && !rst});
`ifdef DEC_ERR_EN
            check_output($sformatf("dut%0d err n=%0d", d, n), {7'b0, f[0]}, {7'b0, n == err_at[d]});
`endif
        end
    endtask

    task automatic set_in(input int d, input bit v, input int s);
        cur_v[d] = v;
        cur_s[d] = s;
        case (d)
            0:       begin va = v; sa = 2'(s); end
            1:       begin vb = v; sb = 2'(s); end
            default: begin vc = v; sc = 3'(s); end
        endcase
    endtask

    task automatic apply_stimulus();
        bit rdy [3];
        for (int d = 0; d < 3; d++) rdy[d] = !m_active(d) && !rst;
        @(posedge clk);
        n++;
        for (int d = 0; d < 3; d++) begin
            taken[d] = cur_v[d] && rdy[d];
            if (taken[d]) begin
`ifdef DEC_ERR_EN
                if (cur_s[d] >= nout[d]) err_at[d] = n;
                else begin acc[d] = n; code[d] = cur_s[d]; end
`else
                acc[d]  = n;
                code[d] = cur_s[d];
`endif
            end
        end
        #1;
        check_all();
    endtask

    // Pending codes are held until the handshake takes them.
    task automatic random_inputs();
        for (int d = 0; d < 3; d++) begin
            if (!cur_v[d] || taken[d]) begin
                set_in(d, $urandom_range(0, 3) != 0, int'($urandom_range(0, smax[d])));
            end
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            acc[d]    = -1000000;
            err_at[d] = -1000000;
        end
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 0);
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // Back-to-back codes on A with valid held high.
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1'b1, k);
            apply_stimulus();
            apply_stimulus();
        end
        set_in(0, 1'b0, 0);
        apply_stimulus();

        // Multi-cycle hold on B; valid during busy must not be taken.
        set_in(1, 1'b1, 2);
        repeat (4) apply_stimulus();
        set_in(1, 1'b0, 0);
        repeat (2) apply_stimulus();

        // Illegal code on B.
        set_in(1, 1'b1, 3);
        apply_stimulus();
        set_in(1, 1'b0, 0);
        repeat (5) apply_stimulus();

        // Full 256-cycle hold on C with the top code.
        set_in(2, 1'b1, 7);
        apply_stimulus();
        set_in(2, 1'b0, 0);
        repeat (258) apply_stimulus();

        // Reset two cycles into a C command.
        set_in(2, 1'b1, 1);
        apply_stimulus();
        set_in(2, 1'b0, 0);
        repeat (2) apply_stimulus();
        #3;
        reset_pulse();
        repeat (3) apply_stimulus();

        for (int i = 0; i < 800; i++) begin
            random_inputs();
            apply_stimulus();
        end

        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 0);
        repeat (260) apply_stimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
